// File: rtl/muldiv_stall_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one result bit per clock, plus MTHI/MTLO.
// Latency : DATA_W+1 stall cycles (accept cycle + DATA_W BUSY cycles); result on hi_o/lo_o in the DONE cycle.
// Backpressure : alu_stall_o holds PC and IF/ID until done; optional macro MULDIV_EARLY_OUT_EN shortens multiplies.
module muldiv_stall_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              flush_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              alu_stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DATA_W - 1);

    // Control / operand state
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_neg_res;   // product / quotient must be negated
    logic                r_neg_rem;   // remainder takes the dividend sign
    logic                r_div0;
    logic [DATA_W-1:0]   r_a;         // multiplicand magnitude
    logic [DATA_W-1:0]   r_b;         // multiplier magnitude (shifts right) or divisor magnitude
    logic [DATA_W-1:0]   r_raw_a;     // unmodified dividend, returned in HI on divide by zero
    logic [2*DATA_W-1:0] r_acc;       // mult: partial product; div: {remainder, quotient/dividend}
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    // Operand conditioning
    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;

    // Multiply datapath
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_acc_next;
    logic [2*DATA_W-1:0] w_mul_prod;
    logic [2*DATA_W-1:0] w_mul_fix;
    logic                w_mul_last;

    // Divide datapath
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_diff;
    logic [2*DATA_W-1:0] w_div_acc_next;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    // Completion
    logic                w_last;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_accept    = (r_state == ST_IDLE) & start_i & ~flush_i;
    assign alu_stall_o = (r_state == ST_BUSY) | w_accept;
    assign done_o      = r_done;
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;

    // Signed ops (op_i[0]==0) work on two's-complement magnitudes; signs are reapplied at the end.
    assign w_a_neg = ~op_i[0] & rs_data_i[DATA_W-1];
    assign w_b_neg = ~op_i[0] & rt_data_i[DATA_W-1];
    assign w_a_mag = w_a_neg ? ('0 - rs_data_i) : rs_data_i;
    assign w_b_mag = w_b_neg ? ('0 - rt_data_i) : rt_data_i;

    // Shift-add step: add multiplicand into the upper half, then shift the whole accumulator right.
    assign w_mul_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_acc_next = {w_mul_sum, r_acc[DATA_W-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
    // Stop once the remaining multiplier bits are all zero; the partial product is then
    // still scaled up by the skipped iterations and is realigned with one final shift.
    logic [CNT_W-1:0] w_shamt;
    assign w_shamt    = LP_LAST - r_cnt;
    assign w_mul_prod = w_mul_acc_next >> w_shamt;
    assign w_mul_last = (r_cnt == LP_LAST) | (r_b[DATA_W-1:1] == '0);
`else
    assign w_mul_prod = w_mul_acc_next;
    assign w_mul_last = (r_cnt == LP_LAST);
`endif

    assign w_mul_fix = r_neg_res ? ('0 - w_mul_prod) : w_mul_prod;

    // Restoring step: shift next dividend bit into the remainder, keep the subtraction if non-negative.
    assign w_div_shift    = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_div_diff     = w_div_shift - {1'b0, r_b};
    assign w_div_acc_next = w_div_diff[DATA_W]
                          ? {w_div_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                          : {w_div_diff[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};
    assign w_quo          = w_div_acc_next[DATA_W-1:0];
    assign w_rem          = w_div_acc_next[2*DATA_W-1:DATA_W];

    assign w_last = r_is_div ? (r_cnt == LP_LAST) : w_mul_last;

    // Final HI/LO values; most-negative / -1 falls out naturally (quotient wraps to most-negative, remainder 0).
    always_comb begin
        w_res_hi = w_mul_fix[2*DATA_W-1:DATA_W];
        w_res_lo = w_mul_fix[DATA_W-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_raw_a;
                w_res_lo = '1;
            end else begin
                w_res_lo = r_neg_res ? ('0 - w_quo) : w_quo;
                w_res_hi = r_neg_rem ? ('0 - w_rem) : w_rem;
            end
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_raw_a   <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (hi_we_i) r_hi <= wdata_i;
                    if (lo_we_i) r_lo <= wdata_i;
                    if (w_accept) begin
                        r_is_div  <= op_i[1];
                        r_a       <= w_a_mag;
                        r_b       <= w_b_mag;
                        r_raw_a   <= rs_data_i;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_div0    <= (rt_data_i == '0);
                        r_acc     <= op_i[1] ? {{DATA_W{1'b0}}, w_a_mag} : '0;
                        r_cnt     <= '0;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_is_div) begin
                            r_acc <= w_div_acc_next;
                        end else begin
                            r_acc <= w_mul_acc_next;
                            r_b   <= r_b >> 1;
                        end
                        if (w_last) begin
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (hi_we_i) r_hi <= wdata_i;
                    if (lo_we_i) r_lo <= wdata_i;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_stall_unit.sv
// Bench for muldiv_stall_unit: directed cases with literal expectations plus randomized traffic
// compared every cycle against an arithmetic reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_muldiv_stall_unit;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i, start_i, flush_i, hi_we_i, lo_we_i;
    logic [1:0]   op_i;
    logic [W-1:0] rs_data_i, rt_data_i, wdata_i;
    logic         alu_stall_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk_i = ~clk_i;

    muldiv_stall_unit #(.DATA_W(W), .CNT_W(6)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .rs_data_i   (rs_data_i),
        .rt_data_i   (rt_data_i),
        .flush_i     (flush_i),
        .hi_we_i     (hi_we_i),
        .lo_we_i     (lo_we_i),
        .wdata_i     (wdata_i),
        .alu_stall_o (alu_stall_o),
        .done_o      (done_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result from plain arithmetic; busy = number of BUSY cycles before DONE.
    task automatic ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] hi, output logic [W-1:0] lo, output int busy);
        logic [63:0]  p;
        int signed    sa, sb;
        logic [W-1:0] bmag;
        sa = a;
        sb = b;
        p  = '0;
        hi = '0;
        lo = '0;
        busy = W;
        case (op)
            2'b00: begin p = 64'(longint'(sa) * longint'(sb)); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b};          hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = '0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            bmag = (op == 2'b00 && b[W-1]) ? (32'd0 - b) : b;
            busy = 1;
            for (int i = 0; i < W; i++) if (bmag[i]) busy = i + 1;
        end
`else
        bmag = b;
`endif
    endtask

    // Cycle-level reference model: observable phase, remaining busy cycles, HI/LO.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t         m_st = M_IDLE;
    bit           m_valid = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
    logic         exp_stall;

    always @(negedge clk_i) begin
        if (m_valid) begin
            exp_stall = (m_st == M_BUSY) || (m_st == M_IDLE && start_i && !flush_i);
            check("alu_stall_o", {63'd0, alu_stall_o}, {63'd0, exp_stall});
            check("done_o", {63'd0, done_o}, {63'd0, (m_st == M_DONE)});
            check("hi_o", {32'd0, hi_o}, {32'd0, m_hi});
            check("lo_o", {32'd0, lo_o}, {32'd0, m_lo});
        end
        if (done_o === 1'b1) done_cnt++;
        if (rst_i) begin
            m_st = M_IDLE; m_hi = '0; m_lo = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_st)
                M_IDLE: begin
                    if (start_i && !flush_i) begin
                        ref_result(op_i, rs_data_i, rt_data_i, m_res_hi, m_res_lo, m_left);
                        m_st = M_BUSY;
                    end
                    if (hi_we_i) m_hi = wdata_i;
                    if (lo_we_i) m_lo = wdata_i;
                end
                M_BUSY: begin
                    if (flush_i) m_st = M_IDLE;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_hi = m_res_hi; m_lo = m_res_lo; m_st = M_DONE; end
                    end
                end
                default: begin
                    if (hi_we_i) m_hi = wdata_i;
                    if (lo_we_i) m_lo = wdata_i;
                    m_st = M_IDLE;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
    endtask

    // Waits for the DONE cycle (start_i left as is); n counts stall cycles from the start cycle.
    task automatic wait_done(output int n);
        bit ok;
        ok = 1'b0;
        n  = 1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done_o === 1'b1) begin ok = 1'b1; break; end
            n++;
        end
        check("done_timeout", {63'd0, ok}, 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    int n, d0, exp_len;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        op_i = 2'b00; rs_data_i = '0; rt_data_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("reset_hi", {32'd0, hi_o}, 64'd0);
        check("reset_lo", {32'd0, lo_o}, 64'd0);
        check("reset_stall", {63'd0, alu_stall_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);

        // MULTU 3 x 5
`ifdef MULDIV_EARLY_OUT_EN
        exp_len = 4;
`else
        exp_len = 33;
`endif
        start_op(2'b01, 32'd3, 32'd5);
        wait_done(n);
        start_i = 1'b0;
        check("multu_len", 64'(n), 64'(exp_len));
        check("multu_hi", {32'd0, hi_o}, 64'h0);
        check("multu_lo", {32'd0, lo_o}, 64'hF);
        tick();

        // MULT -2 x 3
        start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        start_i = 1'b0;
        check("mult_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo_o}, 64'hFFFF_FFFA);
        tick();

        // DIV -7 / 2
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        start_i = 1'b0;
        check("div_len", 64'(n), 64'd33);
        check("div_lo", {32'd0, lo_o}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
        tick();

        // DIVU 7 / 0
        start_op(2'b11, 32'd7, 32'd0);
        wait_done(n);
        start_i = 1'b0;
        check("divu0_len", 64'(n), 64'd33);
        check("divu0_hi", {32'd0, hi_o}, 64'h7);
        check("divu0_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
        tick();

        // Flush at BUSY cycle 10
        d0 = done_cnt;
        start_op(2'b11, 32'd100, 32'd3);
        repeat (10) tick();
        start_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_stall", {63'd0, alu_stall_o}, 64'd0);
        check("flush_hi", {32'd0, hi_o}, 64'h7);
        check("flush_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
        repeat (40) tick();
        check("flush_no_done", 64'(done_cnt - d0), 64'd0);

        // MTLO in IDLE
        lo_we_i = 1'b1; wdata_i = 32'h1234_5678;
        tick();
        lo_we_i = 1'b0;
        check("mtlo", {32'd0, lo_o}, 64'h1234_5678);

        // MTHI while BUSY is ignored
        start_op(2'b01, 32'd6, 32'd7);
        tick();
        hi_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        tick();
        hi_we_i = 1'b0;
        wait_done(n);
        start_i = 1'b0;
        check("mthi_busy_hi", {32'd0, hi_o}, 64'h0);
        check("mthi_busy_lo", {32'd0, lo_o}, 64'd42);
        tick();

        // Reset mid-BUSY
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) tick();
        start_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_busy_hi", {32'd0, hi_o}, 64'h0);
        check("rst_busy_lo", {32'd0, lo_o}, 64'h0);
        check("rst_busy_stall", {63'd0, alu_stall_o}, 64'd0);

        // Back-to-back MULTU then DIVU with start_i held through DONE
        d0 = done_cnt;
        start_op(2'b01, 32'd1234, 32'd10);
        wait_done(n);
        check("b2b_mul_lo", {32'd0, lo_o}, 64'd12340);
        start_op(2'b11, 32'd100, 32'd7);
        check("b2b_done_stall", {63'd0, alu_stall_o}, 64'd0);
        tick();
        check("b2b_accept_stall", {63'd0, alu_stall_o}, 64'd1);
        wait_done(n);
        start_i = 1'b0;
        check("b2b_div_lo", {32'd0, lo_o}, 64'd14);
        check("b2b_div_hi", {32'd0, hi_o}, 64'd2);
        repeat (3) tick();
        check("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

        // MTLO in DONE overrides the fresh result
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(n);
        start_i = 1'b0; lo_we_i = 1'b1; wdata_i = 32'hAAAA_5555;
        tick();
        lo_we_i = 1'b0;
        check("mt_done_lo", {32'd0, lo_o}, 64'hAAAA_5555);
        check("mt_done_hi", {32'd0, hi_o}, 64'h0);

        // Signed overflow
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        start_i = 1'b0;
        check("ovf_lo", {32'd0, lo_o}, 64'h8000_0000);
        check("ovf_hi", {32'd0, hi_o}, 64'h0);
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            rst_i     = (($urandom % 600) == 0);
            start_i   = (($urandom % 3) == 0);
            flush_i   = (($urandom % 50) == 0);
            op_i      = 2'($urandom % 4);
            rs_data_i = pick();
            rt_data_i = pick();
            hi_we_i   = (($urandom % 10) == 0);
            lo_we_i   = (($urandom % 10) == 0);
            wdata_i   = 32'($urandom);
            tick();
        end
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
